// File: rtl/imem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_responder_if
//  Description : Fetch-stage <-> instruction-memory handshake bundle.
//                Request channel : req_valid / req_ready / req_addr, flush
//                Response channel: rsp_valid / rsp_ready / rsp_instr / rsp_err
//                Status          : rsp_count (completed response handshakes)
//                master = fetch stage, slave = instruction memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic [15:0] rsp_count;

    modport master (
        output req_valid, req_addr, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_err, rsp_count
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_err, rsp_count
    );
endinterface
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : imem_responder
//  Description : Memory end of the instruction-fetch interface. Accepts one
//                fetch request at a time, waits WAIT_CYCLES wait states, then
//                presents the 32-bit instruction word (or an error for a
//                misaligned / out-of-range address) until the fetch stage
//                takes it. flush abandons any in-flight fetch.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-low reset (0 = in reset)
//                bus   - imem_responder_if.slave (request, response, count)
//  Parameters  : DEPTH       - ROM size in 32-bit words
//                WAIT_CYCLES - wait states between accept and response
//                INIT_FILE   - reserved; ROM holds the MOV r0,#i pattern
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter     INIT_FILE   = ""
) (
    input  wire logic        clk,
    input  wire logic        reset,
    imem_responder_if.slave  bus
);

    localparam int          WCNT_W   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [31:0] c_MOV_R0 = 32'hE3A0_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [WCNT_W-1:0]   cnt_q,    cnt_d;
    logic [31:0]         instr_q,  instr_d;
    logic                err_q,    err_d;
    logic [15:0]         count_q,  count_d;

    logic                w_req_ready;
    logic                w_accept;
    logic                w_misaligned;
    logic                w_out_of_range;
    logic                w_err;
    logic [31:0]         w_rom_word;

    // ------------------------------------------------------------------
    // Address check uses the full 32-bit address so aliasing high bits
    // never reach a valid ROM word.
    // ------------------------------------------------------------------
    assign w_misaligned   = (bus.req_addr[1:0] != 2'b00);
    assign w_out_of_range = (bus.req_addr[31:2] >= 30'(DEPTH));
    assign w_err          = w_misaligned | w_out_of_range;

    // Word i holds MOV r0,#i; only consulted when the index is in range.
    assign w_rom_word = c_MOV_R0 | {2'b00, bus.req_addr[31:2]};

    assign w_req_ready = reset & (state_q == ST_IDLE) & ~bus.flush;
    assign w_accept    = bus.req_valid & w_req_ready;

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        err_d   = err_q;
        count_d = count_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    // Response data is captured at accept and held untouched
                    // until the next accept, which keeps it stable in RESP.
                    instr_d = w_err ? 32'h0 : w_rom_word;
                    err_d   = w_err;
                    cnt_d   = WCNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - WCNT_W'(1);
                if (cnt_q == WCNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    count_d = count_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A redirect kills the fetch outright, including one that is being
        // handed over this very cycle; in IDLE req_ready is already low.
        if (bus.flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            count_d = count_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            instr_q <= 32'h0;
            err_q   <= 1'b0;
            count_q <= 16'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_instr = instr_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_responder
//  Description : Self-checking bench for imem_responder. Instance A uses
//                WAIT_CYCLES=2, instance B uses WAIT_CYCLES=0. Expected words,
//                error flags, latencies and counts come from a reference model
//                built from the address rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

    localparam int DEPTH = 64;
    localparam int WC_A  = 2;
    localparam int WC_B  = 0;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;
    int   exp_count_a;
    int   exp_count_b;

    imem_responder_if bus_a ();
    imem_responder_if bus_b ();

    imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC_A), .INIT_FILE("")) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC_B), .INIT_FILE("")) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic [31:0] addr);
        return ((addr % 4) != 0) || ((addr / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        if (model_err(addr)) return 32'h0;
        return 32'hE3A00000 | (addr / 4);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present a request on A and return just after the accept edge.
    task automatic accept_a(input logic [31:0] addr);
        int n;
        bus_a.req_valid = 1'b1;
        bus_a.req_addr  = addr;
        #1;
        n = 0;
        while (bus_a.req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL accept_timeout addr=%h req_ready=%b required=1", addr, bus_a.req_ready);
        end
        step();
        bus_a.req_valid = 1'b0;
    endtask

    // Full fetch on A: latency, data, optional backpressure, handshake, count.
    task automatic fetch_a(input logic [31:0] addr, input int hold);
        int          n;
        logic [31:0] ew;
        logic        ee;
        ew = model_word(addr);
        ee = model_err(addr);
        accept_a(addr);
        n = 1;
        while (bus_a.rsp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (n !== WC_A + 1) begin
            bad++;
            $display("FAIL latency addr=%h got=%0d required=%0d", addr, n, WC_A + 1);
        end
        total++;
        if (bus_a.rsp_instr !== ew || bus_a.rsp_err !== ee) begin
            bad++;
            $display("FAIL rsp_data addr=%h got=%h/%b required=%h/%b",
                     addr, bus_a.rsp_instr, bus_a.rsp_err, ew, ee);
        end
        for (int h = 0; h < hold; h++) begin
            step();
            total++;
            if (bus_a.rsp_valid !== 1'b1 || bus_a.rsp_instr !== ew || bus_a.req_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold addr=%h valid=%b instr=%h req_ready=%b required 1/%h/0",
                         addr, bus_a.rsp_valid, bus_a.rsp_instr, bus_a.req_ready, ew);
            end
        end
        bus_a.rsp_ready = 1'b1;
        step();
        bus_a.rsp_ready = 1'b0;
        exp_count_a = (exp_count_a + 1) % 65536;
        total++;
        if (bus_a.rsp_valid !== 1'b0 || bus_a.rsp_count !== 16'(exp_count_a) || bus_a.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL after_hs addr=%h valid=%b count=%0d req_ready=%b required 0/%0d/1",
                     addr, bus_a.rsp_valid, bus_a.rsp_count, bus_a.req_ready, exp_count_a);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        total++;
        if (bus_a.req_ready !== 1'b0 || bus_a.rsp_valid !== 1'b0 || bus_a.rsp_count !== 16'h0 ||
            bus_a.rsp_instr !== 32'h0 || bus_a.rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_a rdy=%b vld=%b cnt=%0d instr=%h err=%b required all 0",
                     bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_count, bus_a.rsp_instr, bus_a.rsp_err);
        end
        total++;
        if (bus_b.req_ready !== 1'b0 || bus_b.rsp_valid !== 1'b0 || bus_b.rsp_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_b rdy=%b vld=%b cnt=%0d required all 0",
                     bus_b.req_ready, bus_b.rsp_valid, bus_b.rsp_count);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus_a.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release req_ready=%b required=1", bus_a.req_ready);
        end
        exp_count_a = 0;
        exp_count_b = 0;
    endtask

    task automatic test_basic();
        fetch_a(32'h0000_0008, 0);
        fetch_a(32'h0000_0000, 0);
    endtask

    task automatic test_errors();
        fetch_a(32'h0000_000A, 0);
        fetch_a(32'h0000_0100, 0);
        fetch_a(32'h0000_00FC, 0);   // last valid word
        fetch_a(32'hFFFF_FFFC, 0);   // aligned, only high bits out of range
        fetch_a(32'h0000_0003, 0);
    endtask

    task automatic test_backpressure();
        fetch_a(32'h0000_0014, 5);
    endtask

    task automatic test_flush();
        // flush in IDLE blocks accept
        bus_a.flush = 1'b1;
        #1;
        total++;
        if (bus_a.req_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle req_ready=%b required=0", bus_a.req_ready);
        end
        bus_a.flush = 1'b0;
        step();
        // flush during WAIT
        accept_a(32'h0000_0010);
        bus_a.flush = 1'b1;
        step();
        bus_a.flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus_a.rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_wait_rsp cycle=%0d rsp_valid=%b required=0", i, bus_a.rsp_valid);
            end
            step();
        end
        total++;
        if (bus_a.rsp_count !== 16'(exp_count_a)) begin
            bad++;
            $display("FAIL flush_wait_count got=%0d required=%0d", bus_a.rsp_count, exp_count_a);
        end
        fetch_a(32'h0000_0004, 0);
        // flush coincident with the response handshake
        accept_a(32'h0000_0008);
        for (int i = 0; i < 20 && bus_a.rsp_valid !== 1'b1; i++) step();
        bus_a.flush     = 1'b1;
        bus_a.rsp_ready = 1'b1;
        step();
        bus_a.flush     = 1'b0;
        bus_a.rsp_ready = 1'b0;
        #1;
        total++;
        if (bus_a.rsp_valid !== 1'b0 || bus_a.rsp_count !== 16'(exp_count_a) || bus_a.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_hs vld=%b cnt=%0d rdy=%b required 0/%0d/1",
                     bus_a.rsp_valid, bus_a.rsp_count, bus_a.req_ready, exp_count_a);
        end
    endtask

    task automatic test_back_to_back();
        int          acc_cyc [$];
        logic [31:0] expq    [$];
        logic [31:0] addr;
        logic [31:0] e;
        int          n;
        addr = 32'h0000_0020;
        bus_a.req_valid = 1'b1;
        bus_a.rsp_ready = 1'b1;
        n = 0;
        while (n < 40 && (n < 20 || expq.size() > 0)) begin
            if (n >= 20) bus_a.req_valid = 1'b0;
            bus_a.req_addr = addr;
            #1;
            if (bus_a.req_valid && bus_a.req_ready) begin
                acc_cyc.push_back(cyc);
                expq.push_back(model_word(addr));
            end
            if (bus_a.rsp_valid === 1'b1) begin
                e = (expq.size() > 0) ? expq.pop_front() : 32'hDEAD_BEEF;
                exp_count_a = (exp_count_a + 1) % 65536;
                total++;
                if (bus_a.rsp_instr !== e) begin
                    bad++;
                    $display("FAIL b2b_data got=%h required=%h", bus_a.rsp_instr, e);
                end
            end
            step();
            if (acc_cyc.size() > 0 && acc_cyc[acc_cyc.size()-1] == cyc - 1) addr = addr + 4;
            n++;
        end
        bus_a.req_valid = 1'b0;
        bus_a.rsp_ready = 1'b0;
        total++;
        if (acc_cyc.size() < 4 || expq.size() != 0) begin
            bad++;
            $display("FAIL b2b_accepts got=%0d pending=%0d required>=4/0", acc_cyc.size(), expq.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            total++;
            if (acc_cyc[i] - acc_cyc[i-1] !== WC_A + 2) begin
                bad++;
                $display("FAIL b2b_spacing got=%0d required=%0d", acc_cyc[i] - acc_cyc[i-1], WC_A + 2);
            end
        end
        total++;
        if (bus_a.rsp_count !== 16'(exp_count_a)) begin
            bad++;
            $display("FAIL b2b_count got=%0d required=%0d", bus_a.rsp_count, exp_count_a);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0000_0000;
        addrs[1] = 32'h0000_0003;
        addrs[2] = 32'h0000_0084;
        for (int i = 0; i < 3; i++) begin
            bus_b.req_valid = 1'b1;
            bus_b.req_addr  = addrs[i];
            #1;
            total++;
            if (bus_b.req_ready !== 1'b1) begin
                bad++;
                $display("FAIL zw_ready got=%b required=1", bus_b.req_ready);
            end
            step();
            bus_b.req_valid = 1'b0;
            total++;
            if (bus_b.rsp_valid !== 1'b1 || bus_b.rsp_instr !== model_word(addrs[i]) ||
                bus_b.rsp_err !== model_err(addrs[i])) begin
                bad++;
                $display("FAIL zw_rsp addr=%h vld=%b instr=%h err=%b required 1/%h/%b", addrs[i],
                         bus_b.rsp_valid, bus_b.rsp_instr, bus_b.rsp_err,
                         model_word(addrs[i]), model_err(addrs[i]));
            end
            bus_b.rsp_ready = 1'b1;
            step();
            bus_b.rsp_ready = 1'b0;
            exp_count_b++;
            total++;
            if (bus_b.rsp_valid !== 1'b0 || bus_b.rsp_count !== 16'(exp_count_b)) begin
                bad++;
                $display("FAIL zw_hs vld=%b cnt=%0d required 0/%0d", bus_b.rsp_valid, bus_b.rsp_count, exp_count_b);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0:       addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
                1:       addr = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
                2:       addr = 32'($urandom_range(DEPTH, 4 * DEPTH)) * 4;
                default: addr = $urandom;
            endcase
            fetch_a(addr, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic test_async_reset();
        accept_a(32'h0000_0008);
        total++;
        if (bus_a.rsp_count === 16'h0) begin
            bad++;
            $display("FAIL async_pre count=%0d required nonzero", bus_a.rsp_count);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (bus_a.rsp_valid !== 1'b0 || bus_a.rsp_count !== 16'h0 || bus_a.req_ready !== 1'b0 ||
            bus_a.rsp_instr !== 32'h0 || bus_b.rsp_count !== 16'h0) begin
            bad++;
            $display("FAIL async_reset vld=%b cnt=%0d rdy=%b instr=%h cntb=%0d required all 0",
                     bus_a.rsp_valid, bus_a.rsp_count, bus_a.req_ready, bus_a.rsp_instr, bus_b.rsp_count);
        end
        step();
        reset = 1'b1;
        exp_count_a = 0;
        exp_count_b = 0;
        #1;
        total++;
        if (bus_a.req_ready !== 1'b1 || bus_a.rsp_count !== 16'h0) begin
            bad++;
            $display("FAIL async_release rdy=%b cnt=%0d required 1/0", bus_a.req_ready, bus_a.rsp_count);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (bus_a.rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL async_stale cycle=%0d rsp_valid=%b required=0", i, bus_a.rsp_valid);
            end
        end
        fetch_a(32'h0000_000C, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        exp_count_a = 0;
        exp_count_b = 0;
        reset = 1'b0;
        bus_a.req_valid = 1'b0; bus_a.req_addr = 32'h0; bus_a.flush = 1'b0; bus_a.rsp_ready = 1'b0;
        bus_b.req_valid = 1'b0; bus_b.req_addr = 32'h0; bus_b.flush = 1'b0; bus_b.rsp_ready = 1'b0;

        test_reset();
        test_basic();
        test_errors();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_zero_wait();
        test_random();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
